useq_loader: RTL and testbench
==============================

Name: useq_loader

Overview:
- Program-memory and boot-loader stage directly upstream of the useq core.
- Holds the 256x8 program RAM that the core fetches from via mem_addr/mem_data.
- Accepts a framed byte stream from the host (UART or SPI byte layer) and writes it into the RAM.
- Holds the core in reset during a load and releases it only after a frame whose checksum passes.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker accepted in IDLE.
- TIMEOUT, 1000, max cycles between accepted bytes inside a frame before abort; counter width is $clog2(TIMEOUT+1).
- BOOT_RUN, 0, if 1 then core_rst_n goes high right after reset (RAM preloaded by synthesis init); if 0 the core waits for the first good frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  8  host byte
- in_valid  in  1  host byte valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_addr  in  8  core fetch address (registered inside the core)
- mem_data  out  8  RAM[mem_addr], combinational read
- core_rst_n  out  1  active-low reset to the core
- busy  out  1  high while state != IDLE
- err  out  1  sticky frame error; cleared on next accepted SYNC_BYTE
- frames_ok  out  8  count of good frames, wraps 255->0

Behaviour:
- Reset values: in_ready=1, core_rst_n=BOOT_RUN, busy=0, err=0, frames_ok=0, state=IDLE, timeout counter=0.
- RAM contents are not cleared by rst_n.
- Byte accept condition: in_valid && in_ready.
- in_ready is 0 only in the DONE state.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> ADDR, core_rst_n<=0, err<=0. Any other byte is dropped and the state stays IDLE.
  - ADDR: accepted byte -> wptr<=byte, sum<=byte, go LEN.
  - LEN: accepted byte -> remaining<=byte (0 means 256; remaining is 9 bits), sum<=sum+byte, go DATA.
  - DATA: each accepted byte:
    - RAM[wptr]<=byte, written on the same clock edge.
    - wptr<=wptr+1, wrapping 8'hFF->8'h00.
    - sum<=sum+byte, remaining<=remaining-1.
    - When remaining reaches 1 on this accept -> CHK.
  - CHK: accepted byte b; if (sum+b) mod 256 == 0 -> DONE, otherwise -> IDLE with err<=1 and core_rst_n held at 0.
  - DONE: lasts exactly one cycle. frames_ok<=frames_ok+1, core_rst_n<=1, then -> IDLE.
- Checksum: 8-bit two's-complement sum over addr, len and data. A valid frame sums to zero including the CHK byte.
- Partial data from a bad or aborted frame stays in the RAM. The core stays in reset until a good frame arrives.
- Timeout:
  - In ADDR, LEN, DATA and CHK, the counter increments every cycle with no accept and clears on each accept.
  - On reaching TIMEOUT: -> IDLE, err<=1, core_rst_n stays 0.
- SYNC_BYTE arriving inside a frame is treated as ordinary data; there is no resync mid-frame.
- Read port: mem_data = RAM[mem_addr] with zero latency. The core's FETCH latches it the cycle after mem_addr updates.
- A write to the address currently on mem_addr shows the new value on mem_data the cycle after the write edge. This case is harmless because the core is in reset during any write.
- rst_n low mid-frame: state returns to IDLE, counters clear, core_rst_n=BOOT_RUN, and bytes already written remain in the RAM.
- Latency: core_rst_n rises one cycle after the CHK accept (the DONE cycle). The core starts FETCH at PC=0 on the following edge.

Test Plan:
- Good frame: 55, 00, 03, 11, 22, 33, then CHK=0x100-(0+3+0x11+0x22+0x33)=0x97.
  - RAM[0..2]=11,22,33.
  - core_rst_n low from the cycle after SYNC until the DONE cycle, then 1.
  - frames_ok=1, err=0.
- Bad checksum: the same frame with CHK=0x98.
  - RAM[0..2] written.
  - err=1, core_rst_n stays 0, frames_ok unchanged.
  - A following good frame clears err and releases the core.
- Address wrap with LEN=0: 55, FE, 00, then 256 data bytes d[i]=i, then CHK.
  - RAM[FE]=0, RAM[FF]=1, RAM[00]=2 ... RAM[FD]=FF.
  - Exactly 256 data accepts occur before the CHK state.
- Timeout: 55, 10, 05, AA, then idle for TIMEOUT cycles.
  - busy drops and err=1 on cycle TIMEOUT.
  - RAM[10]=AA.
  - The next 55 is accepted as SYNC.
- Backpressure and noise:
  - Bytes 00, 7F sent in IDLE are dropped and the state stays IDLE.
  - in_valid held high continuously through a frame gives in_ready=0 only in the DONE cycle; no byte is lost or duplicated.
- Integration: load a useq program that writes 8'h5A to o_port, then run.
  - After core_rst_n rises, mem_data tracks mem_addr.
  - o_port==8'h5A within the expected cycle count.
  - A reset pulse mid-load keeps the core in reset (BOOT_RUN=0).

Source files
------------

// File: rtl/useq_loader.sv
// useq_loader: boot loader and 256x8 program RAM for the useq core.
// Receives a framed byte stream (SYNC, ADDR, LEN, DATA..., CHK), writes the
// payload into program RAM, and keeps the core in reset until a frame whose
// checksum passes has been loaded.
module useq_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'h55,
    parameter int         TIMEOUT   = 1000,
    parameter bit         BOOT_RUN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       core_rst_n,
    output logic       busy,
    output logic       err,
    output logic [7:0] frames_ok
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       wptr_q;
    logic [7:0]       sum_q;
    logic [8:0]       remaining_q;
    logic [CNT_W-1:0] cnt_q;
    logic             core_rst_n_q;
    logic             err_q;
    logic [7:0]       frames_ok_q;
    logic [7:0]       mem_q [0:255];

    logic             accept_d;
    logic [7:0]       sum_d;
    logic             timed_out_d;

    // Handshake and running checksum derived from the current state.
    always_comb begin
        accept_d    = in_valid && in_ready;
        sum_d       = sum_q + in_data;
        timed_out_d = (cnt_q == CNT_LAST);
    end

    assign in_ready   = (state_q != S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign core_rst_n = core_rst_n_q;
    assign err        = err_q;
    assign frames_ok  = frames_ok_q;
    assign mem_data   = mem_q[mem_addr];

    // Program RAM write port; contents survive rst_n so aborted loads persist.
    always_ff @(posedge clk) begin
        if (accept_d && state_q == S_DATA) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // Frame-parsing FSM with inter-byte timeout and core reset control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wptr_q       <= 8'h00;
            sum_q        <= 8'h00;
            remaining_q  <= 9'd0;
            cnt_q        <= '0;
            core_rst_n_q <= BOOT_RUN;
            err_q        <= 1'b0;
            frames_ok_q  <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept_d && in_data == SYNC_BYTE) begin
                        state_q      <= S_ADDR;
                        core_rst_n_q <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end

                S_ADDR, S_LEN, S_DATA, S_CHK: begin
                    if (accept_d) begin
                        cnt_q <= '0;
                        case (state_q)
                            S_ADDR: begin
                                wptr_q  <= in_data;
                                sum_q   <= in_data;
                                state_q <= S_LEN;
                            end
                            S_LEN: begin
                                // A length byte of zero encodes a full 256-byte payload.
                                remaining_q <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                                sum_q       <= sum_d;
                                state_q     <= S_DATA;
                            end
                            S_DATA: begin
                                wptr_q      <= wptr_q + 8'h01;
                                sum_q       <= sum_d;
                                remaining_q <= remaining_q - 9'd1;
                                if (remaining_q == 9'd1) begin
                                    state_q <= S_CHK;
                                end
                            end
                            default: begin
                                if (sum_d == 8'h00) begin
                                    state_q <= S_DONE;
                                end else begin
                                    state_q <= S_IDLE;
                                    err_q   <= 1'b1;
                                end
                            end
                        endcase
                    end else if (timed_out_d) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    frames_ok_q  <= frames_ok_q + 8'h01;
                    core_rst_n_q <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_useq_loader.sv
// Directed bench for useq_loader: frame loading, checksum handling, address
// wrap, timeout, noise, backpressure, program fetch and mid-load reset.
module tb_useq_loader;

    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       core_rst_n;
    logic       busy;
    logic       err;
    logic [7:0] frames_ok;

    int total  = 0;
    int passed = 0;
    int stalls = 0;

    useq_loader #(
        .SYNC_BYTE(8'h55),
        .TIMEOUT  (TIMEOUT),
        .BOOT_RUN (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .err       (err),
        .frames_ok (frames_ok)
    );

    always #5 clk = ~clk;

    // One comparison: counts, asserts, reports on mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a byte at a falling edge and hold it until the loader can take it.
    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 8) begin
            stalls++;
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
        mem_addr = a;
        #1;
        chk(tag, {24'd0, mem_data}, {24'd0, exp});
    endtask

    logic [7:0] prog [0:3];

    initial begin
        prog[0] = 8'h10; prog[1] = 8'h5A; prog[2] = 8'h20; prog[3] = 8'hFF;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        mem_addr = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        chk("rst_frames_ok",  {24'd0, frames_ok},  32'd0);
        rst_n = 1'b1;

        // Noise in IDLE is dropped.
        send_byte(8'h00);
        send_byte(8'h7F);
        go_idle();
        chk("noise_busy", {31'd0, busy}, 32'd0);
        chk("noise_err",  {31'd0, err},  32'd0);

        // Good frame.
        send_byte(8'h55);
        send_byte(8'h00);
        chk("good_core_held", {31'd0, core_rst_n}, 32'd0);
        chk("good_busy",      {31'd0, busy},       32'd1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h97);
        go_idle();
        chk("done_in_ready", {31'd0, in_ready},   32'd0);
        chk("done_core",     {31'd0, core_rst_n}, 32'd0);
        @(negedge clk);
        chk("good_core_rel",  {31'd0, core_rst_n}, 32'd1);
        chk("good_frames_ok", {24'd0, frames_ok},  32'd1);
        chk("good_err",       {31'd0, err},        32'd0);
        chk("good_busy_end",  {31'd0, busy},       32'd0);
        chk_mem("good_ram0", 8'h00, 8'h11);
        chk_mem("good_ram1", 8'h01, 8'h22);
        chk_mem("good_ram2", 8'h02, 8'h33);

        // Bad checksum.
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h98);
        go_idle();
        chk("bad_err",       {31'd0, err},        32'd1);
        chk("bad_core",      {31'd0, core_rst_n}, 32'd0);
        chk("bad_frames_ok", {24'd0, frames_ok},  32'd1);
        chk("bad_busy",      {31'd0, busy},       32'd0);
        repeat (3) @(negedge clk);
        chk("bad_core_hold", {31'd0, core_rst_n}, 32'd0);

        // Good frame with in_valid held high, straight into the wrap frame.
        stalls = 0;
        send_byte(8'h55);
        send_byte(8'h00);
        chk("resync_err_clr", {31'd0, err}, 32'd0);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h97);
        send_byte(8'h55);
        send_byte(8'hFE);
        chk("bp_stalls",    stalls,                    32'd1);
        chk("bp_frames_ok", {24'd0, frames_ok},        32'd2);
        chk("bp_core_low",  {31'd0, core_rst_n},       32'd0);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(i[7:0]);
        send_byte(8'h82);
        go_idle();
        @(negedge clk);
        chk("wrap_frames_ok", {24'd0, frames_ok},  32'd3);
        chk("wrap_core",      {31'd0, core_rst_n}, 32'd1);
        chk("wrap_err",       {31'd0, err},        32'd0);
        chk_mem("wrap_ramFE", 8'hFE, 8'h00);
        chk_mem("wrap_ramFF", 8'hFF, 8'h01);
        chk_mem("wrap_ram00", 8'h00, 8'h02);
        chk_mem("wrap_ram7F", 8'h7F, 8'h81);
        chk_mem("wrap_ramFD", 8'hFD, 8'hFF);

        // Timeout mid-frame.
        send_byte(8'h55);
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'hAA);
        go_idle();
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_busy_before", {31'd0, busy}, 32'd1);
        chk("to_err_before",  {31'd0, err},  32'd0);
        @(negedge clk);
        chk("to_busy_after", {31'd0, busy},       32'd0);
        chk("to_err_after",  {31'd0, err},        32'd1);
        chk("to_core",       {31'd0, core_rst_n}, 32'd0);
        chk_mem("to_ram10", 8'h10, 8'hAA);
        send_byte(8'h55);
        go_idle();
        chk("to_resync_busy", {31'd0, busy}, 32'd1);
        chk("to_resync_err",  {31'd0, err},  32'd0);
        // Finish this frame as a program load at address 0.
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        send_byte(8'h73);
        go_idle();
        @(negedge clk);
        chk("prog_core",      {31'd0, core_rst_n}, 32'd1);
        chk("prog_frames_ok", {24'd0, frames_ok},  32'd4);
        // Fetch model: PC steps from 0 each cycle once the core is released.
        for (int pc = 0; pc < 4; pc++) begin
            mem_addr = pc[7:0];
            #1;
            chk($sformatf("fetch_%0d", pc), {24'd0, mem_data}, {24'd0, prog[pc]});
            @(negedge clk);
        end

        // Reset pulse mid-load.
        send_byte(8'h55);
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy",      {31'd0, busy},       32'd0);
        chk("mrst_core",      {31'd0, core_rst_n}, 32'd0);
        chk("mrst_frames_ok", {24'd0, frames_ok},  32'd0);
        chk("mrst_err",       {31'd0, err},        32'd0);
        chk_mem("mrst_ram20", 8'h20, 8'hA1);
        chk_mem("mrst_ram21", 8'h21, 8'hA2);
        repeat (3) @(negedge clk);
        chk("mrst_core_hold", {31'd0, core_rst_n}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
